// File: rtl/recog_result_fmt.sv
// Recognition result formatter: latches a digit and a feature-point count, converts the
// count to three BCD digits by double-dabble and holds the frame for a minimum display time.
module recog_result_fmt #(
   parameter int unsigned HOLD_CYCLES = 25_000_000,
   parameter logic [3:0]  BLANK_CODE  = 4'hA,
   parameter int unsigned CNT_MAX     = 999
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] digit,
   input  logic [9:0] point_cnt,
   output logic [3:0] num,
   output logic [3:0] point_num1,
   output logic [3:0] point_num2,
   output logic [3:0] point_num3,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {IDLE, CONV, HOLD} state_e;

   localparam int unsigned       HOLD_W    = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
   localparam logic [9:0]        CNT_SAT   = 10'(CNT_MAX);
   localparam logic [3:0]        LAST_BIT  = 4'd9;

   state_e            state_q, state_d;
   logic [3:0]        bit_cnt_q;
   logic [9:0]        bin_q;
   logic [11:0]       bcd_q;
   logic [11:0]       bcd_adj;
   logic [11:0]       bcd_next;
   logic [3:0]        digit_q;
   logic [HOLD_W-1:0] hold_cnt_q;
   logic [15:0]       frame_q;
   logic              done_q;
   logic              accept;
   logic              hold_last;

   assign accept    = in_valid && in_ready;
   assign hold_last = (hold_cnt_q == HOLD_LAST);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (in_valid) state_d = CONV;
         CONV:    if (bit_cnt_q == LAST_BIT) state_d = (HOLD_CYCLES == 0) ? IDLE : HOLD;
         HOLD:    if (hold_last) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state_q == IDLE);
      busy     = (state_q != IDLE);
   end

   // Add-3 on each nibble >= 5, then shift the top binary bit into the BCD accumulator.
   always_comb begin
      bcd_adj = bcd_q;
      for (int n = 0; n < 3; n++) begin
         if (bcd_q[4*n +: 4] >= 4'd5) begin
            bcd_adj[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
         end
      end
      bcd_next = {bcd_adj[10:0], bin_q[9]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bin_q      <= '0;
         bcd_q      <= '0;
         bit_cnt_q  <= '0;
         digit_q    <= BLANK_CODE;
         hold_cnt_q <= '0;
         frame_q    <= {4{BLANK_CODE}};
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (accept) begin
            digit_q   <= (digit > 4'd9) ? BLANK_CODE : digit;
            bin_q     <= (point_cnt > CNT_SAT) ? CNT_SAT : point_cnt;
            bcd_q     <= '0;
            bit_cnt_q <= '0;
         end else if (state_q == CONV) begin
            bcd_q     <= bcd_next;
            bin_q     <= {bin_q[8:0], 1'b0};
            bit_cnt_q <= bit_cnt_q + 4'd1;
            // The whole frame loads on one edge so the display never shows a mixed result.
            if (bit_cnt_q == LAST_BIT) begin
               frame_q <= {digit_q, bcd_next};
               done_q  <= 1'b1;
            end
         end
         if (state_q == HOLD) begin
            hold_cnt_q <= hold_last ? '0 : hold_cnt_q + HOLD_W'(1);
         end
      end
   end

   assign num        = frame_q[15:12];
   assign point_num1 = frame_q[11:8];
   assign point_num2 = frame_q[7:4];
   assign point_num3 = frame_q[3:0];
   assign done       = done_q;

endmodule
